// File: rtl/gpu_fetch.sv
// gpu_fetch: sequential read engine for the GPU buffer window.
// It walks BASE..BASE+LENGTH-1 from a programmable offset, keeps one read
// outstanding at a time, and buffers the returned words in a small FIFO.
// The FIFO drives a valid/ready stream toward the pixel pipeline.
module gpu_fetch #(
  parameter int WORDSIZE   = 16,
  parameter int BASE       = 3072,
  parameter int LENGTH     = 3072,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WORDSIZE-1:0] start_offs,
  input  logic [WORDSIZE-1:0] count,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] mem_addr,
  output logic                mem_en,
  input  logic [WORDSIZE-1:0] mem_rdata,
  input  logic                mem_ready,
  output logic [WORDSIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WORDSIZE-1:0] BASE_W   = WORDSIZE'(BASE);
  localparam logic [WORDSIZE-1:0] LENGTH_W = WORDSIZE'(LENGTH);
  localparam logic [WORDSIZE-1:0] LAST_W   = WORDSIZE'(LENGTH - 1);
  localparam logic [CW-1:0]       DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t               state_reg, state_next;
  logic                 done_reg, done_next;
  logic [WORDSIZE-1:0]  offs_reg;
  logic [WORDSIZE-1:0]  remaining_reg;

  // FIFO storage, pointers and the registered head word
  logic [WORDSIZE-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [CW-1:0]        fill_reg, fill_after_pop;
  logic [WORDSIZE-1:0]  head_reg;

  logic                 pop, push, load, flush, space;

  // A pop happens whenever the consumer takes a valid head.
  assign pop            = (fill_reg != '0) && out_ready;
  assign fill_after_pop = fill_reg - CW'(pop);
  // Room for the single in-flight word once this cycle's pop is counted.
  assign space          = fill_after_pop < DEPTH_C;
  assign rd_ptr_inc     = rd_ptr_reg + PW'(1);

  assign busy      = (state_reg != S_IDLE);
  assign done      = done_reg;
  assign mem_addr  = BASE_W + offs_reg;
  assign out_valid = (fill_reg != '0);
  assign out_data  = head_reg;

  // State and done-pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic; abort outranks every other event outside IDLE
  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    if (state_reg == S_IDLE) begin
      if (start && !abort) begin
        if (count == '0) done_next  = 1'b1;
        else             state_next = S_REQ;
      end
    end else if (abort) begin
      state_next = S_IDLE;
      done_next  = 1'b1;
    end else begin
      case (state_reg)
        S_REQ:   if (space) state_next = S_WAIT;
        S_WAIT:  if (mem_ready)
                   state_next = (remaining_reg == WORDSIZE'(1)) ? S_DRAIN : S_REQ;
        S_DRAIN: if (fill_after_pop == '0) begin
                   state_next = S_IDLE;
                   done_next  = 1'b1;
                 end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Per-state strobes: memory request, FIFO push, parameter load, flush
  always_comb begin
    mem_en = 1'b0;
    push   = 1'b0;
    load   = 1'b0;
    flush  = 1'b0;
    case (state_reg)
      S_IDLE:  load   = start && !abort && (count != '0);
      S_REQ:   mem_en = space && !abort;
      S_WAIT:  push   = mem_ready && !abort;
      default: ;
    endcase
    if (state_reg != S_IDLE) flush = abort;
  end

  // Offset and remaining-word counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offs_reg      <= '0;
      remaining_reg <= '0;
    end else if (load) begin
      offs_reg      <= start_offs % LENGTH_W;
      remaining_reg <= count;
    end else if (push) begin
      offs_reg      <= (offs_reg == LAST_W) ? '0 : offs_reg + WORDSIZE'(1);
      remaining_reg <= remaining_reg - WORDSIZE'(1);
    end
  end

  // FIFO storage write (no reset so it can map onto RAM)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= mem_rdata;
  end

  // FIFO pointers, fill level and registered head word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
      head_reg   <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_inc;
      fill_reg <= fill_after_pop + CW'(push);
      // An empty FIFO takes the incoming word straight into the head;
      // otherwise the head advances to the next stored entry on a pop.
      if (push && (fill_after_pop == '0)) head_reg <= mem_rdata;
      else if (pop)                       head_reg <= fifo_mem[rd_ptr_inc];
    end
  end

endmodule

// File: tb/tb_gpu_fetch.sv
// tb_gpu_fetch: randomized bench for gpu_fetch with a transfer-level
// reference model (expected address/data lists, FIFO occupancy, busy/done).
module tb_gpu_fetch;
  localparam int WS     = 16;
  localparam int BASE   = 3072;
  localparam int LENGTH = 3072;
  localparam int DEPTH  = 8;

  logic          clk, rst_n, start, abort, busy, done, mem_en, mem_ready;
  logic          out_valid, out_ready;
  logic [WS-1:0] start_offs, count, mem_addr, mem_rdata, out_data;

  gpu_fetch #(.WORDSIZE(WS), .BASE(BASE), .LENGTH(LENGTH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_offs(start_offs),
    .count(count), .abort(abort), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int occ = 0, req_cnt = 0, pop_cnt = 0, xfer_cnt = 0;
  int lat_max = 1, rdy_mode = 0, dly = 0, pend_addr = 0;
  bit pend = 0, model_busy = 0, exp_done = 0, done_seen = 0;
  bit start_q = 0, abort_q = 0, late_q = 0;
  int addr_q[$], data_q[$], addr_log[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, sample #1 later,
  // then advance the reference model to what the next rising edge does.
  task automatic cycle();
    bit push_now, pop_now, nd, nb;
    int a;
    @(negedge clk);
    start   = start_q;  start_q = 1'b0;
    abort   = abort_q;  abort_q = 1'b0;
    out_ready = (rdy_mode == 0) ? 1'b1 :
                (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_ready = 1'b0;
    push_now  = 1'b0;
    if (late_q) begin
      mem_ready = 1'b1;
      mem_rdata = 16'hDEAD;
      late_q    = 1'b0;
    end else if (pend && abort && model_busy) begin
      pend = 1'b0;
    end else if (pend) begin
      if (dly == 0) begin
        mem_ready = 1'b1;
        mem_rdata = WS'(pend_addr ^ 32'hA5A5);
        pend      = 1'b0;
        push_now  = 1'b1;
      end else begin
        dly--;
      end
    end
    #1;
    chk("done",  int'(done), int'(exp_done));
    chk("busy",  int'(busy), int'(model_busy));
    chk("valid", int'(out_valid), int'(occ > 0));
    if (done) done_seen = 1'b1;
    pop_now = out_valid && out_ready;
    if (pop_now) begin
      if (data_q.size() > 0) chk("data", int'(out_data), data_q.pop_front());
      else                   chk("extra_pop", pop_cnt + 1, xfer_cnt);
      pop_cnt++;
    end
    if (mem_en) begin
      chk("one_outstanding", int'(pend), 0);
      chk("space", int'((occ - int'(pop_now)) <= DEPTH - 1), 1);
      addr_log.push_back(int'(mem_addr));
      if (addr_q.size() > 0) chk("addr", int'(mem_addr), addr_q.pop_front());
      else                   chk("extra_req", req_cnt + 1, xfer_cnt);
      req_cnt++;
      pend      = 1'b1;
      pend_addr = int'(mem_addr);
      dly       = int'($urandom_range(1, lat_max)) - 1;
    end
    nd = 1'b0;
    nb = model_busy;
    if (model_busy) begin
      if (abort) begin
        nd = 1'b1; nb = 1'b0;
      end else if (pop_now && pop_cnt == xfer_cnt) begin
        nd = 1'b1; nb = 1'b0;
      end
    end else if (start && !abort) begin
      if (count == '0) begin
        nd = 1'b1;
      end else begin
        nb = 1'b1;
        xfer_cnt = int'(count);
        req_cnt = 0;
        pop_cnt = 0;
        addr_q.delete();
        data_q.delete();
        addr_log.delete();
        for (int k = 0; k < xfer_cnt; k++) begin
          a = BASE + ((int'(start_offs) % LENGTH + k) % LENGTH);
          addr_q.push_back(a);
          data_q.push_back(a ^ 32'hA5A5);
        end
      end
    end
    occ = occ + int'(push_now) - int'(pop_now);
    if (model_busy && abort) begin
      occ = 0;
      addr_q.delete();
      data_q.delete();
      pend = 1'b0;
    end
    exp_done   = nd;
    model_busy = nb;
    cyc++;
  endtask

  task automatic begin_xfer(input int offs, input int cnt);
    start_offs = WS'(offs);
    count      = WS'(cnt);
    start_q    = 1'b1;
    done_seen  = 1'b0;
    req_cnt    = 0;
    pop_cnt    = 0;
    xfer_cnt   = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) cycle();
    chk("timeout", int'(done_seen), 1);
  endtask

  task automatic xfer(input int offs, input int cnt, input int lmax, input int rmode);
    lat_max  = lmax;
    rdy_mode = rmode;
    begin_xfer(offs, cnt);
    wait_done(3000);
    chk("reqs", req_cnt, cnt);
    chk("pops", pop_cnt, cnt);
    $display("[TB] xfer offs=%0d count=%0d lat<=%0d reqs=%0d pops=%0d end_cycle=%0d",
             offs, cnt, lmax, req_cnt, pop_cnt, cyc);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mem_ready = 1'b0;
    out_ready = 1'b0; start_offs = '0; count = '0; mem_rdata = '0;
    #1;
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_addr",  int'(mem_addr), BASE);
    chk("rst_data",  int'(out_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic transfer and wrap-around
    xfer(0, 4, 1, 0);
    chk("basic_a0", addr_log[0], 3072);
    chk("basic_a3", addr_log[3], 3075);
    xfer(3070, 4, 1, 0);
    chk("wrap_a0", addr_log[0], 6142);
    chk("wrap_a1", addr_log[1], 6143);
    chk("wrap_a2", addr_log[2], 3072);
    chk("wrap_a3", addr_log[3], 3073);

    // Backpressure: the FIFO fills, then requests stop
    lat_max  = 1;
    rdy_mode = 2;
    begin_xfer(10, 12);
    for (int i = 0; i < 40; i++) cycle();
    chk("bp_reqs", req_cnt, DEPTH);
    rdy_mode = 0;
    wait_done(500);
    chk("bp_total_reqs", req_cnt, 12);
    chk("bp_total_pops", pop_cnt, 12);
    $display("[TB] backpressure count=12 reqs=%0d pops=%0d", req_cnt, pop_cnt);

    // Variable latency with random consumer stalls
    xfer(500, 20, 5, 1);

    // count=0: done next cycle, nothing requested
    xfer(7, 0, 1, 0);

    // start while busy is ignored
    lat_max  = 3;
    rdy_mode = 1;
    begin_xfer(100, 6);
    for (int i = 0; i < 4; i++) cycle();
    start_offs = 16'd999;
    count      = 16'd2;
    start_q    = 1'b1;
    wait_done(500);
    chk("busy_start_reqs", req_cnt, 6);
    chk("busy_start_pops", pop_cnt, 6);
    $display("[TB] start-while-busy reqs=%0d pops=%0d", req_cnt, pop_cnt);

    // Abort after three words, then a stray mem_ready
    lat_max  = 3;
    rdy_mode = 0;
    begin_xfer(40, 10);
    for (int i = 0; i < 200 && pop_cnt < 3; i++) cycle();
    chk("abort_progress", int'(pop_cnt >= 3), 1);
    abort_q = 1'b1;
    cycle();
    late_q = 1'b1;
    cycle();
    chk("abort_done_seen", int'(done_seen), 1);
    cycle();
    chk("abort_late_valid", int'(out_valid), 0);
    for (int i = 0; i < 4; i++) cycle();
    $display("[TB] abort after %0d pops, done_seen=%0d", pop_cnt, done_seen);

    // Asynchronous reset in the middle of a transfer
    lat_max  = 2;
    rdy_mode = 1;
    begin_xfer(2000, 10);
    for (int i = 0; i < 200 && pop_cnt < 2; i++) cycle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   int'(busy), 0);
    chk("mid_rst_done",   int'(done), 0);
    chk("mid_rst_mem_en", int'(mem_en), 0);
    chk("mid_rst_valid",  int'(out_valid), 0);
    chk("mid_rst_addr",   int'(mem_addr), BASE);
    chk("mid_rst_data",   int'(out_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_busy = 1'b0; exp_done = 1'b0; occ = 0; pend = 1'b0;
    addr_q.delete(); data_q.delete();
    done_seen = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("mid_rst_no_done", int'(done_seen), 0);
    $display("[TB] reset mid-transfer after %0d pops", pop_cnt);

    // Random transfers
    for (int t = 0; t < 5; t++)
      xfer(int'($urandom_range(0, 65535)), int'($urandom_range(1, 24)),
           int'($urandom_range(1, 4)), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
